crop_inference_scheduler: RTL and testbench
===========================================

// Module: crop_inference_scheduler
// PURPOSE
//  Time-multiplexes NUM_CROPS per-crop normalised pixel streams onto one shared CNN engine, in crop-index order.
//  Drives engine ap_start and collects one RESULT_W result per crop into a frame bank.
//  Publishes all crop results of a frame as one AXIS beat, tagged with a frame count.
//  Sits between the crop_norm instances and the output stage; replaces fixed-5-crop glue with generic NUM_CROPS.
// PARAMETERS
//  NUM_CROPS      3     crops per frame (>=2)
//  PIX_W          8     pixel width into engine
//  CROP_PIXELS    400   beats per crop stream (OUT_ROWS*OUT_COLS)
//  RESULT_W       160   engine result width per crop
//  FRAME_CNT_W    16    frame counter width
//  TIMEOUT_CYCLES 65535 result watchdog limit (used only with SCHED_TIMEOUT_EN)
// PORTS
//  clk              in  1                   clock
//  reset            in  1                   async, active-high
//  crop_valid       in  NUM_CROPS           crop i normalised, ready to stream (level)
//  s_axis_tvalid    in  NUM_CROPS           per-crop pixel valid
//  s_axis_tready    out NUM_CROPS           per-crop pixel ready
//  s_axis_tdata     in  NUM_CROPS*PIX_W     crop i at [i*PIX_W +: PIX_W]
//  eng_ap_start     out 1                   engine start pulse
//  eng_ap_ready     in  1                   engine can accept new start
//  eng_s_axis_tvalid/tready/tdata  out/in/out  1/1/PIX_W   pixels to engine
//  eng_m_axis_tvalid in 1; eng_m_axis_tready out 1; eng_m_axis_tdata in RESULT_W   engine result
//  m_axis_tvalid    out 1                   frame result valid
//  m_axis_tready    in  1                   downstream ready
//  m_axis_tdata     out NUM_CROPS*RESULT_W  crop i result at [i*RESULT_W +: RESULT_W]
//  m_axis_tuser     out NUM_CROPS+FRAME_CNT_W  {err_mask, frame_cnt}
//  crop_idx         out $clog2(NUM_CROPS)   crop currently owning engine
//  overflow_cnt     out 16                  frames dropped, saturating
// BEHAVIOUR
//  Reset: all outputs 0; state WAIT_CROP; crop_idx=0; frame_cnt=0; eng_rdy_st=1.
//  eng_rdy_st: set on eng_ap_ready; cleared when eng_ap_start=1; set wins if both occur.
//  WAIT_CROP -> START when crop_valid[crop_idx] && eng_rdy_st.
//  START: eng_ap_start=1 for exactly one cycle -> STREAM.
//  STREAM: eng_s_axis_tvalid=s_axis_tvalid[crop_idx]; s_axis_tready[crop_idx]=eng_s_axis_tready (combinational).
//   Other s_axis_tready bits are 0. Beat counter wraps at CROP_PIXELS-1; last transfer -> WAIT_RESULT.
//  Outside STREAM: every s_axis_tready=0 and eng_s_axis_tvalid=0.
//  WAIT_RESULT: eng_m_axis_tready=1 (0 in every other state).
//   On result beat: bank[crop_idx]<=tdata; err[crop_idx]<=0.
//   If crop_idx==NUM_CROPS-1 -> PUBLISH; else crop_idx+1 -> WAIT_CROP.
//  PUBLISH, single cycle, always -> WAIT_CROP with crop_idx=0:
//   Output slot free (!m_axis_tvalid, or m_axis_tvalid&&m_axis_tready this cycle):
//    load tdata=bank, tuser={err,frame_cnt}; m_axis_tvalid=1 next cycle.
//   Slot occupied and not draining: frame dropped; overflow_cnt+1, saturating at 16'hFFFF.
//   frame_cnt+1 in both cases, wrapping mod 2^FRAME_CNT_W (drops show as tuser gaps).
//  m_axis_tvalid clears on m_axis_tvalid&&m_axis_tready unless reloaded the same cycle.
//   tdata/tuser held stable while valid&&!ready.
//  Latency: last result beat -> PUBLISH +1 cycle -> m_axis_tvalid +1 cycle (2 cycles).
//  Mid-operation reset: aborts immediately to reset state; partial bank discarded, no output beat.
// CONFIGURATION
//  SCHED_TIMEOUT_EN defined:
//   A cycle counter runs in WAIT_RESULT.
//   After TIMEOUT_CYCLES cycles with no result: bank[crop_idx]<=0, err[crop_idx]<=1, advance as if a result arrived.
//  Not defined: WAIT_RESULT waits indefinitely; err_mask is constant 0; no counter logic.
// TESTING
//  NUM_CROPS=3, CROP_PIXELS=4, ideal engine (result = sum of pixels) -> one m_axis beat; slots 0..2 = sums; tuser frame_cnt=0.
//  Toggle eng_s_axis_tready and s_axis_tvalid randomly -> no beat lost or duplicated; each crop count exactly 4.
//  eng_ap_ready held low 50 cycles after crop 0 -> eng_ap_start for crop 1 only after eng_ap_ready; one pulse per crop.
//  m_axis_tready=0 across 2 full frames -> frame 0 held stable; overflow_cnt=1; after drain next beat frame_cnt=2.
//  Reset asserted mid-STREAM of crop 1 -> all outputs 0; next frame starts at crop 0 with frame_cnt=0.
//  SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=20, engine silent for crop 2 -> slot 2 = 0; err_mask=3'b100; frame still published.

Source files
------------

// File: rtl/crop_inference_scheduler.sv
// crop_inference_scheduler: shares one CNN engine across NUM_CROPS crop streams.
// Crops are served in index order; per-crop results are banked, one AXIS beat per frame.
//
// Ports:
//   clk, reset                     clock, async active-high reset
//   crop_valid[NUM_CROPS]          crop i ready to stream (level)
//   s_axis_*                       per-crop pixel streams (crop i at [i*PIX_W +: PIX_W])
//   eng_ap_start / eng_ap_ready    engine start pulse / engine can accept a start
//   eng_s_axis_*                   pixels to engine
//   eng_m_axis_*                   per-crop result from engine
//   m_axis_tdata/tuser/tvalid      frame beat: bank, {err_mask, frame_cnt}
//   crop_idx                       crop currently owning the engine
//   overflow_cnt                   frames dropped while the output slot was busy (saturating)
//
// Optional build macro SCHED_TIMEOUT_EN: result watchdog of TIMEOUT_CYCLES.
// A crop that times out gets a zero result and its err_mask bit set.
// Without the macro the scheduler waits forever for each result and err_mask is 0.

module crop_inference_scheduler #(
  parameter int NUM_CROPS      = 3,
  parameter int PIX_W          = 8,
  parameter int CROP_PIXELS    = 400,
  parameter int RESULT_W       = 160,
  parameter int FRAME_CNT_W    = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CROPS-1:0]            crop_valid,
  input  logic [NUM_CROPS-1:0]            s_axis_tvalid,
  output logic [NUM_CROPS-1:0]            s_axis_tready,
  input  logic [NUM_CROPS*PIX_W-1:0]      s_axis_tdata,
  output logic                            eng_ap_start,
  input  logic                            eng_ap_ready,
  output logic                            eng_s_axis_tvalid,
  input  logic                            eng_s_axis_tready,
  output logic [PIX_W-1:0]                eng_s_axis_tdata,
  input  logic                            eng_m_axis_tvalid,
  output logic                            eng_m_axis_tready,
  input  logic [RESULT_W-1:0]             eng_m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [NUM_CROPS*RESULT_W-1:0]   m_axis_tdata,
  output logic [NUM_CROPS+FRAME_CNT_W-1:0] m_axis_tuser,
  output logic [$clog2(NUM_CROPS)-1:0]    crop_idx,
  output logic [15:0]                     overflow_cnt
);

  localparam int IDX_W = $clog2(NUM_CROPS);
  localparam int CNT_W = (CROP_PIXELS > 1) ? $clog2(CROP_PIXELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CROPS - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CROP_PIXELS - 1);

  if (NUM_CROPS < 2) begin : g_bad_crops
    $error("NUM_CROPS must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_WAIT_CROP,
    S_START,
    S_STREAM,
    S_WAIT_RESULT,
    S_PUBLISH
  } state_t;

  state_t state, state_nxt;

  logic                              eng_rdy_st;
  logic [CNT_W-1:0]                  beat_cnt;
  logic [NUM_CROPS-1:0][RESULT_W-1:0] bank;
  logic [NUM_CROPS-1:0]              err;
  logic [FRAME_CNT_W-1:0]            frame_cnt;

  logic pix_xfer;
  logic res_xfer;
  logic tmo_hit;
  logic res_done;
  logic slot_free;
  logic crop_last;

  assign pix_xfer  = (state == S_STREAM) &&
                     s_axis_tvalid[crop_idx] && eng_s_axis_tready;
  assign res_xfer  = (state == S_WAIT_RESULT) && eng_m_axis_tvalid;
  assign res_done  = res_xfer || tmo_hit;
  assign crop_last = (crop_idx == LAST_IDX);
  // The slot can take a new frame if empty or being drained this cycle.
  assign slot_free = !m_axis_tvalid || m_axis_tready;

  assign eng_s_axis_tdata = (state == S_STREAM) ?
                            s_axis_tdata[crop_idx*PIX_W +: PIX_W] : '0;

`ifdef SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // tmo_cnt holds the number of WAIT_RESULT cycles already spent.
  assign tmo_hit = (state == S_WAIT_RESULT) && !eng_m_axis_tvalid &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if ((state == S_WAIT_RESULT) && !res_done) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= '0;
    end else if (res_done) begin
      err[crop_idx] <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = '0;
`endif

  always_comb begin
    state_nxt         = state;
    eng_ap_start      = 1'b0;
    eng_s_axis_tvalid = 1'b0;
    s_axis_tready     = '0;
    eng_m_axis_tready = 1'b0;
    unique case (state)
      S_WAIT_CROP: begin
        if (crop_valid[crop_idx] && eng_rdy_st) state_nxt = S_START;
      end
      S_START: begin
        eng_ap_start = 1'b1;
        state_nxt    = S_STREAM;
      end
      S_STREAM: begin
        eng_s_axis_tvalid       = s_axis_tvalid[crop_idx];
        s_axis_tready[crop_idx] = eng_s_axis_tready;
        if (pix_xfer && (beat_cnt == LAST_BEAT)) state_nxt = S_WAIT_RESULT;
      end
      S_WAIT_RESULT: begin
        eng_m_axis_tready = 1'b1;
        if (res_done) state_nxt = crop_last ? S_PUBLISH : S_WAIT_CROP;
      end
      S_PUBLISH: begin
        state_nxt = S_WAIT_CROP;
      end
      default: begin
        state_nxt = S_WAIT_CROP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_WAIT_CROP;
    end else begin
      state <= state_nxt;
    end
  end

  // Engine-ready latch: a ready seen in the start cycle keeps the latch set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_rdy_st <= 1'b1;
    end else if (eng_ap_ready) begin
      eng_rdy_st <= 1'b1;
    end else if (eng_ap_start) begin
      eng_rdy_st <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (pix_xfer) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crop_idx <= '0;
      bank     <= '0;
    end else if (state == S_PUBLISH) begin
      crop_idx <= '0;
    end else if (res_done) begin
      bank[crop_idx] <= res_xfer ? eng_m_axis_tdata : '0;
      if (!crop_last) crop_idx <= crop_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt    <= '0;
      overflow_cnt <= '0;
      m_axis_tdata <= '0;
      m_axis_tuser <= '0;
    end else if (state == S_PUBLISH) begin
      frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      if (slot_free) begin
        m_axis_tdata <= bank;
        m_axis_tuser <= {err, frame_cnt};
      end else if (overflow_cnt != 16'hFFFF) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
    end else if ((state == S_PUBLISH) && slot_free) begin
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crop_inference_scheduler.sv
// tb_crop_inference_scheduler: directed bench for crop_inference_scheduler.
// Ideal engine model returns the sum of a crop's pixels.

module tb_crop_inference_scheduler;

  localparam int NC = 3;
  localparam int PW = 8;
  localparam int CP = 4;
  localparam int RW = 16;
  localparam int FW = 16;
  localparam int TO = 20;

  logic                clk = 1'b0;
  logic                reset;
  logic [NC-1:0]       crop_valid;
  logic [NC-1:0]       s_axis_tvalid;
  logic [NC-1:0]       s_axis_tready;
  logic [NC*PW-1:0]    s_axis_tdata;
  logic                eng_ap_start;
  logic                eng_ap_ready;
  logic                eng_s_axis_tvalid;
  logic                eng_s_axis_tready;
  logic [PW-1:0]       eng_s_axis_tdata;
  logic                eng_m_axis_tvalid;
  logic                eng_m_axis_tready;
  logic [RW-1:0]       eng_m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready;
  logic [NC*RW-1:0]    m_axis_tdata;
  logic [NC+FW-1:0]    m_axis_tuser;
  logic [1:0]          crop_idx;
  logic [15:0]         overflow_cnt;

  crop_inference_scheduler #(
    .NUM_CROPS(NC), .PIX_W(PW), .CROP_PIXELS(CP),
    .RESULT_W(RW), .FRAME_CNT_W(FW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .crop_valid(crop_valid),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .eng_ap_start(eng_ap_start), .eng_ap_ready(eng_ap_ready),
    .eng_s_axis_tvalid(eng_s_axis_tvalid),
    .eng_s_axis_tready(eng_s_axis_tready),
    .eng_s_axis_tdata(eng_s_axis_tdata),
    .eng_m_axis_tvalid(eng_m_axis_tvalid),
    .eng_m_axis_tready(eng_m_axis_tready),
    .eng_m_axis_tdata(eng_m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .crop_idx(crop_idx), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int ptr [NC];
  int cnt [NC];
  int acc, pcnt;
  logic res_valid;
  logic [RW-1:0] res_data;
  int rdy_hold, next_hold;
  int cyc;
  int last_res_cyc, rise_cyc;
  logic rnd, silent, mv_prev;
  logic mon, held_set;
  int unstable;
  logic [NC*RW-1:0] held_data;
  logic [NC+FW-1:0] held_user;
  int start_q [$];
  logic [NC*RW-1:0] q_data [$];
  logic [NC+FW-1:0] q_user [$];

  function automatic logic [PW-1:0] pix(int i, int p);
    return PW'(16 * (p / 4) + 4 * i + (p % 4) + 1);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      ptr[i] = 0;
      cnt[i] = 0;
    end
    acc = 0;
    pcnt = 0;
    res_valid = 1'b0;
    res_data = '0;
    rdy_hold = 0;
    next_hold = 1;
    eng_ap_ready = 1'b1;
    mv_prev = 1'b0;
    start_q.delete();
    q_data.delete();
    q_user.delete();
  endtask

  // Called at a negedge; drives inputs, samples, crosses one posedge.
  task automatic step();
    logic px, rx, mx;
    logic [PW-1:0] pd;
    logic [NC-1:0] sx;
    logic [1:0] ci;
    for (int i = 0; i < NC; i++) begin
      s_axis_tvalid[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tdata[i*PW +: PW] = pix(i, ptr[i]);
    end
    eng_s_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    eng_m_axis_tvalid = res_valid;
    eng_m_axis_tdata  = res_data;
    if (rdy_hold > 0) begin
      rdy_hold--;
      if (rdy_hold == 0) eng_ap_ready = 1'b1;
    end
    #1;
    if (eng_ap_start) begin
      start_q.push_back(cyc);
      eng_ap_ready = 1'b0;
      rdy_hold = next_hold;
      next_hold = 1;
    end
    px = eng_s_axis_tvalid && eng_s_axis_tready;
    pd = eng_s_axis_tdata;
    rx = eng_m_axis_tvalid && eng_m_axis_tready;
    sx = s_axis_tvalid & s_axis_tready;
    mx = m_axis_tvalid && m_axis_tready;
    ci = crop_idx;
    if (rx && ci == 2'd2) last_res_cyc = cyc;
    if (m_axis_tvalid && !mv_prev) rise_cyc = cyc;
    mv_prev = m_axis_tvalid;
    if (mx) begin
      q_data.push_back(m_axis_tdata);
      q_user.push_back(m_axis_tuser);
    end
    if (mon && m_axis_tvalid) begin
      if (!held_set) begin
        held_data = m_axis_tdata;
        held_user = m_axis_tuser;
        held_set = 1'b1;
      end else if (held_data !== m_axis_tdata || held_user !== m_axis_tuser) begin
        unstable++;
      end
    end
    @(posedge clk);
    if (px) begin
      acc += int'(pd);
      pcnt++;
      if (pcnt == CP) begin
        if (!(silent && ci == 2'd2)) begin
          res_valid = 1'b1;
          res_data = RW'(acc);
        end
        acc = 0;
        pcnt = 0;
      end
    end
    if (rx) res_valid = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (sx[i]) begin
        ptr[i]++;
        cnt[i]++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_beats(int n, int budget, string tag);
    int k = 0;
    while (q_data.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, 64'(q_data.size()), 64'(n));
  endtask

  task automatic check_frame(string tag, int idx, int s0, int s1, int s2, int user);
    logic [NC*RW-1:0] d;
    logic [NC+FW-1:0] u;
    d = (q_data.size() > idx) ? q_data[idx] : 'x;
    u = (q_user.size() > idx) ? q_user[idx] : 'x;
    check({tag, "_slot0"}, 64'(d[0*RW +: RW]), 64'(s0));
    check({tag, "_slot1"}, 64'(d[1*RW +: RW]), 64'(s1));
    check({tag, "_slot2"}, 64'(d[2*RW +: RW]), 64'(s2));
    check({tag, "_tuser"}, 64'(u), 64'(user));
  endtask

  initial begin
    int k;
    reset = 1'b1;
    crop_valid = '0;
    s_axis_tvalid = '0;
    s_axis_tdata = '0;
    eng_s_axis_tready = 1'b0;
    eng_m_axis_tvalid = 1'b0;
    eng_m_axis_tdata = '0;
    m_axis_tready = 1'b0;
    rnd = 1'b0;
    silent = 1'b0;
    mon = 1'b0;
    held_set = 1'b0;
    unstable = 0;
    cyc = 0;
    last_res_cyc = -100;
    rise_cyc = 0;
    held_data = '0;
    held_user = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    #1;
    check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_ap_start", 64'(eng_ap_start), 64'd0);
    check("rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("rst_eng_s_tvalid", 64'(eng_s_axis_tvalid), 64'd0);
    check("rst_eng_m_tready", 64'(eng_m_axis_tready), 64'd0);
    check("rst_crop_idx", 64'(crop_idx), 64'd0);
    check("rst_overflow", 64'(overflow_cnt), 64'd0);
    check("rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_m_tuser", 64'(m_axis_tuser), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Frame 0: random handshake toggling
    rnd = 1'b1;
    crop_valid = '1;
    m_axis_tready = 1'b1;
    wait_beats(1, 600, "f0_beat");
    check_frame("f0", 0, 10, 26, 42, 0);
    check("f0_cnt0", 64'(cnt[0]), 64'd4);
    check("f0_cnt1", 64'(cnt[1]), 64'd4);
    check("f0_cnt2", 64'(cnt[2]), 64'd4);
    check("f0_starts", 64'(start_q.size()), 64'd3);
    check("f0_latency", 64'(rise_cyc - last_res_cyc), 64'd2);

    // Frame 1: engine not ready for 50 cycles after crop 0 start
    rnd = 1'b0;
    next_hold = 50;
    start_q.delete();
    wait_beats(2, 600, "f1_beat");
    check_frame("f1", 1, 74, 90, 106, 1);
    check("f1_starts", 64'(start_q.size()), 64'd3);
    k = (start_q.size() >= 2) ? start_q[1] - start_q[0] : 0;
    check("f1_start_gap_ge51", 64'(k >= 51), 64'd1);

    // Reset mid-STREAM of crop 1
    k = 0;
    while (!(crop_idx === 2'd1 && eng_s_axis_tvalid === 1'b1) && k < 300) begin
      step();
      k++;
    end
    check("mid_stream_found", 64'(k < 300), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_crop_idx", 64'(crop_idx), 64'd0);
    check("mid_rst_s_tready", 64'(s_axis_tready), 64'd0);
    check("mid_rst_eng_s_tvalid", 64'(eng_s_axis_tvalid), 64'd0);
    check("mid_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_m_tuser", 64'(m_axis_tuser), 64'd0);
    check("mid_rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Two frames with downstream stalled: first held, second dropped
    m_axis_tready = 1'b0;
    mon = 1'b1;
    held_set = 1'b0;
    unstable = 0;
    k = 0;
    while (overflow_cnt !== 16'd1 && k < 600) begin
      step();
      k++;
    end
    mon = 1'b0;
    check("ovf_cnt", 64'(overflow_cnt), 64'd1);
    check("ovf_valid_held", 64'(m_axis_tvalid), 64'd1);
    check("ovf_stable", 64'(unstable), 64'd0);
    check("ovf_held_tuser", 64'(held_user), 64'd0);
    check("ovf_held_slot2", 64'(held_data[2*RW +: RW]), 64'd42);
    m_axis_tready = 1'b1;
    wait_beats(1, 50, "drain_beat");
    check_frame("drain", 0, 10, 26, 42, 0);
    wait_beats(2, 600, "next_beat");
    check_frame("next", 1, 138, 154, 170, 2);

`ifdef SCHED_TIMEOUT_EN
    // Engine silent for crop 2: watchdog fills slot 2 with 0 and flags it
    silent = 1'b1;
    wait_beats(3, 800, "tmo_beat");
    check_frame("tmo", 2, 202, 218, 0, (4 << FW) | 3);
    silent = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
